qalu_seq: RTL

Parametrised, handshaked fixed-point arithmetic unit for the Q-format datapath. It accepts one operand pair plus an opcode per transaction and computes add, subtract, multiply or divide in sign-magnitude Q(N,Q) format. It saturates on overflow and holds the result until the consumer takes it. It replaces the free-running opcode-mux top level: transactions are explicit valid/ready, and division is tracked by the unit itself rather than by a fixed wait.

---
 rtl/qalu_pkg.sv | 20 ++
 rtl/qalu_div_iter.sv | 85 ++++++++
 rtl/qalu_seq.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/qalu_pkg.sv
// qalu_pkg: shared types for the sequential Q-format arithmetic unit.
//   opcode_e : operation select carried on the opcode port
//   state_e  : control states of qalu_seq
package qalu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_MUL = 2'b01,
    OP_DIV = 2'b10,
    OP_SUB = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DIV  = 2'b10,
    DONE = 2'b11
  } state_e;

endpackage

// File: rtl/qalu_div_iter.sv
// qalu_div_iter: restoring divider for sign-magnitude Q(N,Q) magnitudes.
// Divides (mag_a << Q) by mag_b, producing one quotient bit per clock over
// N-1+Q iterations after start.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load operands and begin a division (mag_b must be nonzero)
//   mag_a      : dividend magnitude
//   mag_b      : divisor magnitude
//   quotient   : low N-1 quotient bits, valid while done = 1
//   done       : high during the cycle whose clock edge performs the last step
//   ovf        : quotient has nonzero bits above N-2, valid while done = 1
module qalu_div_iter #(
  parameter int N = 32,
  parameter int Q = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-2:0] mag_a,
  input  logic [N-2:0] mag_b,
  output logic [N-2:0] quotient,
  output logic         done,
  output logic         ovf
);

  localparam int W  = N - 1 + Q;
  localparam int CW = $clog2(W + 1);

  logic          busy_reg;
  logic [CW-1:0] count_reg;
  logic [W-1:0]  dvd_reg;
  logic [N-2:0]  dvs_reg;
  logic [N-2:0]  rem_reg;
  // Only W-1 bits are kept: the final step's full W-bit quotient is
  // presented combinationally, so the top bit never needs storage.
  logic [W-2:0]  quo_reg;

  logic [N-1:0]  trial;
  logic          ge;
  logic [N-2:0]  rem_next;
  logic [W-1:0]  quo_next;
  logic [W-1:0]  quo_hi;

  always_comb begin
    trial    = {rem_reg, dvd_reg[W-1]};
    ge       = (trial >= {1'b0, dvs_reg});
    // The true difference is below the divisor, so it fits in N-1 bits and
    // modulo subtraction of the low bits gives the exact remainder.
    rem_next = ge ? (trial[N-2:0] - dvs_reg) : trial[N-2:0];
    quo_next = {quo_reg, ge};
    quo_hi   = quo_next >> (N - 1);
  end

  // Outputs reflect the step being taken this cycle so the caller can latch
  // the final quotient on the same edge as the last iteration.
  assign done     = busy_reg && (count_reg == CW'(1));
  assign quotient = quo_next[N-2:0];
  assign ovf      = |quo_hi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg  <= 1'b0;
      count_reg <= '0;
      dvd_reg   <= '0;
      dvs_reg   <= '0;
      rem_reg   <= '0;
      quo_reg   <= '0;
    end else if (start) begin
      busy_reg  <= 1'b1;
      count_reg <= CW'(W);
      dvd_reg   <= W'(mag_a) << Q;
      dvs_reg   <= mag_b;
      rem_reg   <= '0;
      quo_reg   <= '0;
    end else if (busy_reg) begin
      dvd_reg   <= dvd_reg << 1;
      rem_reg   <= rem_next;
      quo_reg   <= quo_next[W-2:0];
      count_reg <= count_reg - CW'(1);
      if (count_reg == CW'(1)) begin
        busy_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/qalu_seq.sv
// qalu_seq: handshaked sign-magnitude Q(N,Q) arithmetic unit with
// saturation. One operand pair per transaction; result held until taken.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (in_ready while idle)
//   opcode              : 00 add, 01 mul, 10 div, 11 sub
//   a, b                : sign-magnitude operands
//   out_valid/out_ready : result handshake
//   result              : sign-magnitude result (never negative zero)
//   ovf                 : result saturated
//   div_zero            : divide with zero divisor magnitude
module qalu_seq
  import qalu_pkg::*;
#(
  parameter int N = 32,
  parameter int Q = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   opcode,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         ovf,
  output logic         div_zero
);

  localparam int M = N - 1;

  state_e       state_reg, state_next;
  logic [N-1:0] a_reg, b_reg;
  opcode_e      op_reg;
  logic [N-1:0] result_reg;
  logic         ovf_reg, dz_reg;

  logic         accept, div_start;
  logic [M-1:0] div_q;
  logic         div_done, div_q_ovf;

  // Divider loads straight from the input bus on the accepting edge, so its
  // iterations line up with the cycles spent in DIV.
  assign accept    = (state_reg == IDLE) && in_valid;
  assign div_start = accept && (opcode == OP_DIV) && (b[M-1:0] != '0);

  qalu_div_iter #(.N(N), .Q(Q)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .mag_a    (a[M-1:0]),
    .mag_b    (b[M-1:0]),
    .quotient (div_q),
    .done     (div_done),
    .ovf      (div_q_ovf)
  );

  // Combinational add/sub/mul/div-by-zero from the operand registers.
  logic         sa, sb_eff;
  logic [M-1:0] ma, mb;
  logic [M:0]   sum;
  logic [2*M-1:0] prod, prod_sh;
  logic         calc_sign, calc_ovf, calc_dz;
  logic [M-1:0] calc_mag;
  logic [N-1:0] calc_result;
  logic [M-1:0] div_mag;
  logic [N-1:0] div_result;

  always_comb begin
    sa        = a_reg[N-1];
    ma        = a_reg[M-1:0];
    mb        = b_reg[M-1:0];
    sb_eff    = b_reg[N-1] ^ (op_reg == OP_SUB);
    sum       = {1'b0, ma} + {1'b0, mb};
    prod      = (2*M)'(ma) * (2*M)'(mb);
    prod_sh   = prod >> Q;
    calc_sign = 1'b0;
    calc_mag  = '0;
    calc_ovf  = 1'b0;
    calc_dz   = 1'b0;
    case (op_reg)
      OP_ADD, OP_SUB: begin
        if (sa == sb_eff) begin
          calc_sign = sa;
          if (sum[M]) begin
            calc_mag = '1;
            calc_ovf = 1'b1;
          end else begin
            calc_mag = sum[M-1:0];
          end
        end else if (ma >= mb) begin
          calc_sign = sa;
          calc_mag  = ma - mb;
        end else begin
          calc_sign = sb_eff;
          calc_mag  = mb - ma;
        end
      end
      OP_MUL: begin
        calc_sign = sa ^ b_reg[N-1];
        if (prod_sh[2*M-1:M] != '0) begin
          calc_mag = '1;
          calc_ovf = 1'b1;
        end else begin
          calc_mag = prod_sh[M-1:0];
        end
      end
      default: begin
        // Only a zero-divisor divide reaches CALC.
        calc_sign = sa;
        calc_mag  = '1;
        calc_dz   = 1'b1;
      end
    endcase
    calc_result = {calc_sign && (calc_mag != '0), calc_mag};
    div_mag     = div_q_ovf ? '1 : div_q;
    div_result  = {(a_reg[N-1] ^ b_reg[N-1]) && (div_mag != '0), div_mag};
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (in_valid) state_next = div_start ? DIV : CALC;
      CALC: state_next = DONE;
      DIV:  if (div_done) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready  = (state_reg == IDLE);
    out_valid = (state_reg == DONE);
  end

  assign result   = result_reg;
  assign ovf      = ovf_reg;
  assign div_zero = dz_reg;

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg      <= '0;
      b_reg      <= '0;
      op_reg     <= OP_ADD;
      result_reg <= '0;
      ovf_reg    <= 1'b0;
      dz_reg     <= 1'b0;
    end else begin
      if (accept) begin
        a_reg  <= a;
        b_reg  <= b;
        op_reg <= opcode_e'(opcode);
      end
      if (state_reg == CALC) begin
        result_reg <= calc_result;
        ovf_reg    <= calc_ovf;
        dz_reg     <= calc_dz;
      end else if (state_reg == DIV && div_done) begin
        result_reg <= div_result;
        ovf_reg    <= div_q_ovf;
        dz_reg     <= 1'b0;
      end
    end
  end

endmodule
